// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep unit: gate op encoding,
// FSM states and the legal parameter ranges.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int N_IN_MIN = 2;
    localparam int N_IN_MAX = 6;
    localparam int STEP_MIN = 1;
    localparam int STEP_MAX = 255;

    localparam int STEP_CNT_W = $clog2(STEP_MAX + 1);

endpackage

// File: rtl/gate_reduce.sv
// Combinational gate: reduces an N_IN-bit input vector with the selected
// AND / OR / XOR / NAND function.
module gate_reduce
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [1:0]      op_i,
    input  logic [N_IN-1:0] vec_i,
    output logic            y_o
);

    always_comb begin
        y_o = 1'b0;
        case (op_e'(op_i))
            OP_AND:  y_o = &vec_i;
            OP_OR:   y_o = |vec_i;
            OP_XOR:  y_o = ^vec_i;
            OP_NAND: y_o = ~&vec_i;
        endcase
    end

endmodule

// File: rtl/gate_sweep_unit.sv
// Steps a gate through every input pattern, STEP cycles each, counting ones.
// Define GATE_SWEEP_TABLE_EN to add the captured truth_table output.
module gate_sweep_unit
    import gate_sweep_pkg::*;
#(
    parameter  int N_IN  = 2,
    parameter  int STEP  = 10,
    localparam int NPAT  = 2**N_IN,
    localparam int CNT_W = $clog2(NPAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  pattern,
    output logic             f,
    output logic [CNT_W-1:0] ones_count
`ifdef GATE_SWEEP_TABLE_EN
    ,
    output logic [NPAT-1:0]  truth_table
`endif
);

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || STEP < STEP_MIN || STEP > STEP_MAX) begin : g_bad_param
        $error("gate_sweep_unit: N_IN or STEP out of legal range");
    end

    state_e                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [N_IN-1:0]       pattern_q, pattern_d;
    logic [STEP_CNT_W-1:0] step_q, step_d;
    logic                  f_q, f_d;
    logic [CNT_W-1:0]      ones_q, ones_d;
    logic                  clear, new_pat, last_step, last_pat;

    assign last_step = (step_q == STEP_CNT_W'(STEP - 1));
    assign last_pat  = (pattern_q == N_IN'(NPAT - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SWEEP;
            ST_SWEEP: if (last_step && last_pat) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // Sequencing: f and the captures are taken from the next-state pattern, so
    // they change on the same edge as pattern itself.
    always_comb begin
        op_d      = op_q;
        pattern_d = pattern_q;
        step_d    = step_q;
        clear     = 1'b0;
        new_pat   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    pattern_d = '0;
                    step_d    = '0;
                    clear     = 1'b1;
                    new_pat   = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (!last_step) begin
                    step_d = step_q + STEP_CNT_W'(1);
                end else if (!last_pat) begin
                    pattern_d = pattern_q + N_IN'(1);
                    step_d    = '0;
                    new_pat   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    gate_reduce #(.N_IN(N_IN)) u_reduce (
        .op_i  (op_d),
        .vec_i (pattern_d),
        .y_o   (f_d)
    );

    always_comb begin
        ones_d = clear ? '0 : ones_q;
        if (new_pat && f_d) ones_d = ones_d + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            pattern_q <= '0;
            step_q    <= '0;
            f_q       <= 1'b0;
            ones_q    <= '0;
        end else begin
            op_q      <= op_d;
            pattern_q <= pattern_d;
            step_q    <= step_d;
            f_q       <= f_d;
            ones_q    <= ones_d;
        end
    end

`ifdef GATE_SWEEP_TABLE_EN
    logic [NPAT-1:0] table_q, table_d;

    always_comb begin
        table_d = clear ? '0 : table_q;
        if (new_pat) table_d[pattern_d] = f_d;
    end

    always_ff @(posedge clk) begin
        if (rst) table_q <= '0;
        else     table_q <= table_d;
    end

    assign truth_table = table_q;
`endif

    assign pattern    = pattern_q;
    assign f          = f_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Scoreboard bench for gate_sweep_unit: dut0 is N_IN=2/STEP=10, dut1 is N_IN=3/STEP=1.
module tb_gate_sweep_unit;

    localparam int NONE = 100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start0, start1;
    logic [1:0] op0, op1;
    logic       busy0, done0, f0, busy1, done1, f1;
    logic [1:0] pattern0;
    logic [2:0] pattern1, ones0;
    logic [3:0] ones1;
`ifdef GATE_SWEEP_TABLE_EN
    logic [3:0] tt0;
    logic [7:0] tt1;
`endif

    gate_sweep_unit #(.N_IN(2), .STEP(10)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op0),
        .busy(busy0), .done(done0), .pattern(pattern0), .f(f0), .ones_count(ones0)
`ifdef GATE_SWEEP_TABLE_EN
        , .truth_table(tt0)
`endif
    );

    gate_sweep_unit #(.N_IN(3), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1),
        .busy(busy1), .done(done1), .pattern(pattern1), .f(f1), .ones_count(ones1)
`ifdef GATE_SWEEP_TABLE_EN
        , .truth_table(tt1)
`endif
    );

    typedef struct packed {
        logic [2:0] pat;
        logic       f;
        logic [3:0] ones;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    function automatic logic model_f(input logic [1:0] o, input int p, input int n);
        int c = 0;
        for (int b = 0; b < n; b++) if (((p >> b) & 1) != 0) c++;
        case (o)
            2'b00:   return (c == n);
            2'b01:   return (c > 0);
            2'b10:   return (c % 2 == 1);
            default: return (c != n);
        endcase
    endfunction

    // Expected per-cycle outputs from the first SWEEP cycle on; limit truncates a sweep.
    task automatic push_sweep(input int sel, input logic [1:0] opv, input int n_idle, input int limit);
        int n    = (sel == 0) ? 2 : 3;
        int step = (sel == 0) ? 10 : 1;
        int cnt  = 0;
        int ones = 0;
        exp_t e;
        e = '0;
        for (int p = 0; p < (1 << n); p++) begin
            e.f = model_f(opv, p, n);
            if (e.f) ones++;
            e.pat  = 3'(p);
            e.ones = 4'(ones);
            e.busy = 1'b1;
            e.done = 1'b0;
            for (int s = 0; s < step; s++) begin
                if (cnt < limit) q.push_back(e);
                cnt++;
            end
        end
        if (cnt <= limit) begin
            e.done = 1'b1;
            q.push_back(e);
            e.busy = 1'b0;
            e.done = 1'b0;
            for (int k = 0; k < n_idle; k++) q.push_back(e);
        end
    endtask

    task automatic check_cycle(input int sel, input string tag, input int i);
        exp_t e;
        logic [2:0] ap;
        logic [3:0] ao;
        logic af, ab, ad;
        e = q.pop_front();
        if (sel == 0) begin
            ap = {1'b0, pattern0}; af = f0; ao = {1'b0, ones0}; ab = busy0; ad = done0;
        end else begin
            ap = pattern1; af = f1; ao = ones1; ab = busy1; ad = done1;
        end
        checks += 5;
        if (ap !== e.pat)  begin errors++; $display("FAIL %s[%0d] pattern: got %0d want %0d", tag, i, ap, e.pat); end
        if (af !== e.f)    begin errors++; $display("FAIL %s[%0d] f: got %0b want %0b", tag, i, af, e.f); end
        if (ao !== e.ones) begin errors++; $display("FAIL %s[%0d] ones_count: got %0d want %0d", tag, i, ao, e.ones); end
        if (ab !== e.busy) begin errors++; $display("FAIL %s[%0d] busy: got %0b want %0b", tag, i, ab, e.busy); end
        if (ad !== e.done) begin errors++; $display("FAIL %s[%0d] done: got %0b want %0b", tag, i, ad, e.done); end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    // Pops one expectation per cycle; inputs are changed right after each compare.
    task automatic run_checks(input int sel, input string tag, input int chg_at, input logic [1:0] chg_op,
                              input int pulse_at, input int drop_at);
        int i = 0;
        while (q.size() > 0) begin
            check_cycle(sel, tag, i);
            if (i == drop_at) set_start(sel, 1'b0);
            if (i == pulse_at) set_start(sel, 1'b1);
            if (i == pulse_at + 1) set_start(sel, 1'b0);
            if (i == chg_at) begin
                if (sel == 0) op0 = chg_op;
                else          op1 = chg_op;
            end
            @(negedge clk);
            i++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; op0 = 2'b11; op1 = 2'b11;
        repeat (2) @(negedge clk);
        checks += 10;
        if (busy0 !== 1'b0)    begin errors++; $display("FAIL reset busy0: got %0b want 0", busy0); end
        if (done0 !== 1'b0)    begin errors++; $display("FAIL reset done0: got %0b want 0", done0); end
        if (pattern0 !== 2'd0) begin errors++; $display("FAIL reset pattern0: got %0d want 0", pattern0); end
        if (f0 !== 1'b0)       begin errors++; $display("FAIL reset f0: got %0b want 0", f0); end
        if (ones0 !== 3'd0)    begin errors++; $display("FAIL reset ones0: got %0d want 0", ones0); end
        if (busy1 !== 1'b0)    begin errors++; $display("FAIL reset busy1: got %0b want 0", busy1); end
        if (done1 !== 1'b0)    begin errors++; $display("FAIL reset done1: got %0b want 0", done1); end
        if (pattern1 !== 3'd0) begin errors++; $display("FAIL reset pattern1: got %0d want 0", pattern1); end
        if (f1 !== 1'b0)       begin errors++; $display("FAIL reset f1: got %0b want 0", f1); end
        if (ones1 !== 4'd0)    begin errors++; $display("FAIL reset ones1: got %0d want 0", ones1); end
`ifdef GATE_SWEEP_TABLE_EN
        checks += 2;
        if (tt0 !== 4'd0) begin errors++; $display("FAIL reset tt0: got %b want 0000", tt0); end
        if (tt1 !== 8'd0) begin errors++; $display("FAIL reset tt1: got %b want 00000000", tt1); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_and();
        op0 = 2'b00; start0 = 1'b1;
        push_sweep(0, 2'b00, 1, 1000);
        @(negedge clk);
        run_checks(0, "and", NONE, 2'b00, NONE, 0);
`ifdef GATE_SWEEP_TABLE_EN
        checks++;
        if (tt0 !== 4'b1000) begin errors++; $display("FAIL and truth_table: got %b want 1000", tt0); end
`endif
    endtask

    task automatic test_nand_op_change();
        op0 = 2'b11; start0 = 1'b1;
        push_sweep(0, 2'b11, 1, 1000);
        @(negedge clk);
        run_checks(0, "nand", 15, 2'b01, NONE, 0);
`ifdef GATE_SWEEP_TABLE_EN
        checks++;
        if (tt0 !== 4'b0111) begin errors++; $display("FAIL nand truth_table: got %b want 0111", tt0); end
`endif
    endtask

    task automatic test_step1_xor();
        op1 = 2'b10; start1 = 1'b1;
        push_sweep(1, 2'b10, 1, 1000);
        @(negedge clk);
        run_checks(1, "xor", NONE, 2'b00, NONE, 0);
`ifdef GATE_SWEEP_TABLE_EN
        checks++;
        if (tt1 !== 8'b10010110) begin errors++; $display("FAIL xor truth_table: got %b want 10010110", tt1); end
`endif
    endtask

    task automatic test_start_ignored();
        op0 = 2'b01; start0 = 1'b1;
        push_sweep(0, 2'b01, 2, 1000);
        @(negedge clk);
        run_checks(0, "ignore", NONE, 2'b00, 4, 0);
    endtask

    task automatic test_back_to_back();
        op0 = 2'b01; start0 = 1'b1;
        push_sweep(0, 2'b01, 1, 1000);
        push_sweep(0, 2'b01, 1, 1000);
        @(negedge clk);
        run_checks(0, "b2b", NONE, 2'b00, NONE, 42);
    endtask

    task automatic test_reset_mid_sweep();
        op0 = 2'b01; start0 = 1'b1;
        push_sweep(0, 2'b01, 0, 26);
        @(negedge clk);
        run_checks(0, "abort", NONE, 2'b00, NONE, 0);
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (busy0 !== 1'b0)    begin errors++; $display("FAIL abort busy: got %0b want 0", busy0); end
        if (done0 !== 1'b0)    begin errors++; $display("FAIL abort done: got %0b want 0", done0); end
        if (pattern0 !== 2'd0) begin errors++; $display("FAIL abort pattern: got %0d want 0", pattern0); end
        if (ones0 !== 3'd0)    begin errors++; $display("FAIL abort ones_count: got %0d want 0", ones0); end
        if (f0 !== 1'b0)       begin errors++; $display("FAIL abort f: got %0b want 0", f0); end
`ifdef GATE_SWEEP_TABLE_EN
        checks++;
        if (tt0 !== 4'd0) begin errors++; $display("FAIL abort truth_table: got %b want 0000", tt0); end
`endif
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL abort_after[%0d] done/busy: got %0b/%0b want 0/0", k, done0, busy0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_nand_op_change();
        test_step1_xor();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
